// File: rtl/ysyx_22041211_muldiv.sv
// Iterative RV32M multiply/divide unit.
// A shift-add multiplier and a restoring divider share one hi/lo register pair.
// Operands enter as magnitudes and the sign is corrected on the last iteration.
// Divide-by-zero and signed overflow resolve straight from IDLE to DONE.
module ysyx_22041211_muldiv #(
  parameter int DATA_LEN   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_LEN-1:0]   src1_i,
  input  logic [DATA_LEN-1:0]   src2_i,
  input  logic [REG_ADDR_W-1:0] wreg_i,
  input  logic                  wd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_LEN-1:0]   result_o,
  output logic [REG_ADDR_W-1:0] wreg_o,
  output logic                  wd_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_LEN);
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(DATA_LEN - 1);
  localparam logic [DATA_LEN-1:0] MOST_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  // Two's-complement negation at operand/result width.
  function automatic logic [DATA_LEN-1:0] negate(input logic [DATA_LEN-1:0] v);
    return ~v + DATA_LEN'(1);
  endfunction

  // Two's-complement negation of the full double-width product.
  function automatic logic [2*DATA_LEN-1:0] negate_wide(input logic [2*DATA_LEN-1:0] v);
    return ~v + (2*DATA_LEN)'(1);
  endfunction

  state_t                r_state;
  state_t                w_state_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_LEN-1:0]   r_result;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic                  r_wd;

  // Iteration datapath: hi = accumulator/remainder, lo = multiplier/quotient.
  logic [DATA_LEN-1:0]   r_hi;
  logic [DATA_LEN-1:0]   r_lo;
  logic [DATA_LEN-1:0]   r_b;
  logic                  r_is_div;
  logic                  r_hi_half;
  logic                  r_is_rem;
  logic                  r_neg_q;
  logic                  r_neg_r;

  logic                  w_accept;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_LEN-1:0]   w_a_mag;
  logic [DATA_LEN-1:0]   w_b_mag;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_special;
  logic [DATA_LEN-1:0]   w_special_res;
  logic [DATA_LEN:0]     w_sum;
  logic [DATA_LEN:0]     w_shift;
  logic [DATA_LEN:0]     w_diff;
  logic [DATA_LEN-1:0]   w_hi_nx;
  logic [DATA_LEN-1:0]   w_lo_nx;
  logic [2*DATA_LEN-1:0] w_prod;
  logic [DATA_LEN-1:0]   w_final;

  // A flush in the same cycle wins over the offered operation.
  assign w_accept = (r_state == S_IDLE) && in_valid_i && !flush_i;

  // Operand decode: signedness per funct3, magnitudes, and the one-cycle special cases.
  always_comb begin
    w_a_neg    = src1_i[DATA_LEN-1] &&
                 ((op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110));
    w_b_neg    = src2_i[DATA_LEN-1] &&
                 ((op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110));
    w_a_mag    = w_a_neg ? negate(src1_i) : src1_i;
    w_b_mag    = w_b_neg ? negate(src2_i) : src2_i;
    w_div_zero = op_i[2] && (src2_i == '0);
    w_div_ovf  = op_i[2] && !op_i[0] && (src1_i == MOST_NEG) && (src2_i == '1);
    w_special  = w_div_zero || w_div_ovf;
    if (w_div_zero) w_special_res = op_i[1] ? src1_i : '1;
    else            w_special_res = op_i[1] ? '0 : src1_i;
  end

  // One multiply (add-then-shift-right) or restoring-divide (shift-left-then-subtract) step.
  always_comb begin
    w_sum   = {1'b0, r_hi} + {1'b0, r_b};
    w_shift = {r_hi, r_lo[DATA_LEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_is_div) begin
      if (!w_diff[DATA_LEN]) begin
        w_hi_nx = w_diff[DATA_LEN-1:0];
        w_lo_nx = {r_lo[DATA_LEN-2:0], 1'b1};
      end else begin
        w_hi_nx = w_shift[DATA_LEN-1:0];
        w_lo_nx = {r_lo[DATA_LEN-2:0], 1'b0};
      end
    end else if (r_lo[0]) begin
      {w_hi_nx, w_lo_nx} = {w_sum, r_lo[DATA_LEN-1:1]};
    end else begin
      {w_hi_nx, w_lo_nx} = {1'b0, r_hi, r_lo[DATA_LEN-1:1]};
    end
  end

  // Sign correction and half selection applied to the last iteration's outcome.
  always_comb begin
    w_prod = {w_hi_nx, w_lo_nx};
    if (r_neg_q) w_prod = negate_wide(w_prod);
    if (r_is_div) begin
      if (r_is_rem) w_final = r_neg_r ? negate(w_hi_nx) : w_hi_nx;
      else          w_final = r_neg_q ? negate(w_lo_nx) : w_lo_nx;
    end else begin
      w_final = r_hi_half ? w_prod[2*DATA_LEN-1:DATA_LEN] : w_prod[DATA_LEN-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (in_valid_i) w_state_nx = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == LAST) w_state_nx = S_DONE;
      S_DONE: if (out_ready_i) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush_i) w_state_nx = S_IDLE;
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready_o  = (r_state == S_IDLE);
    out_valid_o = (r_state == S_DONE);
    busy_o      = (r_state != S_IDLE);
  end

  // Reset-visible control: iteration counter, result and destination tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_wreg   <= '0;
      r_wd     <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_wreg <= wreg_i;
      r_wd   <= wd_i;
      if (w_special) r_result <= w_special_res;
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST) r_result <= w_final;
    end
  end

  // Iteration registers; contents are don't-care outside CALC so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi      <= '0;
      r_lo      <= w_a_mag;
      r_b       <= w_b_mag;
      r_is_div  <= op_i[2];
      r_hi_half <= (op_i[1:0] != 2'b00);
      r_is_rem  <= op_i[1];
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
    end else if (r_state == S_CALC) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
    end
  end

  assign result_o = r_result;
  assign wreg_o   = r_wreg;
  assign wd_o     = r_wd;

endmodule
